// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: shared state, opcode, ALU_OP and mux encodings for the multi-cycle controller.
package multi_cycle_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: maps a 6-bit opcode to one-hot instruction class flags.
module mc_opcode_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_addi,
  output logic       is_ori,
  output logic       is_j,
  output logic       is_illegal
);
  assign is_r       = opcode == OP_RTYPE;
  assign is_lw      = opcode == OP_LW;
  assign is_sw      = opcode == OP_SW;
  assign is_beq     = opcode == OP_BEQ;
  assign is_addi    = opcode == OP_ADDI;
  assign is_ori     = opcode == OP_ORI;
  assign is_j       = opcode == OP_J;
  assign is_illegal = ~|{is_r, is_lw, is_sw, is_beq, is_addi, is_ori, is_j};
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshake and retire counter.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       ALU_OP,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retire_cnt
);
  state_t state, state_nx;
  logic [5:0] op_q, op_sel;
  logic retire;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_ori, is_j, is_illegal;
  ctrl_t c, o;
  // DECODE sees the live IR field; later states use the copy captured in DECODE
  assign op_sel = state == DECODE ? opcode : op_q;
  mc_opcode_decode u_dec (
    .opcode(op_sel), .is_r(is_r), .is_lw(is_lw), .is_sw(is_sw), .is_beq(is_beq),
    .is_addi(is_addi), .is_ori(is_ori), .is_j(is_j), .is_illegal(is_illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= FETCH;
      op_q       <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) op_q <= opcode;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  always_comb begin
    c        = '0;
    state_nx = state;
    retire   = 1'b0;
    case (state)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        c.pc_src    = PC_ALU;
        state_nx    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        c.alu_src_b  = SRCB_IMM_SH;
        c.pc_write   = is_j;
        c.pc_src     = is_j ? PC_JUMP : PC_ALU;
        c.illegal_op = is_illegal;
        retire       = is_j;
        state_nx     = (is_j | is_illegal) ? FETCH : EXEC;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = (is_r | is_beq) ? SRCB_RT : SRCB_IMM;
        c.alu_op    = is_r ? ALU_FUNCT : is_beq ? ALU_SUB : is_ori ? ALU_OR : ALU_ADD;
        c.pc_src    = is_beq ? PC_ALUOUT : PC_ALU;
        c.pc_write  = is_beq & alu_zero;
        retire      = is_beq;
        state_nx    = (is_r | is_addi | is_ori) ? WB : (is_lw | is_sw) ? MEM : FETCH;
      end
      MEM: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = is_sw;
        retire    = mem_ready & is_sw;
        state_nx  = !mem_ready ? MEM : is_sw ? FETCH : WB;
      end
      WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = is_r;
        c.mem_to_reg = is_lw;
        retire       = 1'b1;
        state_nx     = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end
  // reset forces every output low without waiting for a clock
  assign o          = rst_n ? c : '0;
  assign mem_req    = o.mem_req;
  assign mem_we     = o.mem_we;
  assign iord       = o.iord;
  assign ir_write   = o.ir_write;
  assign pc_write   = o.pc_write;
  assign pc_src     = o.pc_src;
  assign ALU_OP     = o.alu_op;
  assign alu_src_a  = o.alu_src_a;
  assign alu_src_b  = o.alu_src_b;
  assign reg_write  = o.reg_write;
  assign reg_dst    = o.reg_dst;
  assign mem_to_reg = o.mem_to_reg;
  assign illegal_op = o.illegal_op;
endmodule
